// File: rtl/pedestrian_signal.sv
// Pedestrian WALK / DON'T-WALK controller slaved to a vehicle traffic light.
// The push button is synchronized and debounced, then latched as a request.
// A walk phase is granted only on the first clock of a pure-red vehicle phase.
// Leaving pure red aborts the walk, and a red+green lamp combination latches a
// fault that only reset clears.
//
// The phase output is the raw FSM state (00 STOP, 01 WALK, 10 FLASH, 11 FAULT).
module pedestrian_signal #(
    parameter int WALK_CYCLES     = 600000,
    parameter int FLASH_CYCLES    = 300000,
    parameter int FLASH_HALF      = 50000,
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int CNT_W           = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic       car_red,
    input  logic       car_yellow,
    input  logic       car_green,
    output logic       walk,
    output logic       dont_walk,
    output logic       req_pending,
    output logic [1:0] phase,
    output logic       fault
);

    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_WALK  = 2'b01,
        ST_FLASH = 2'b10,
        ST_FAULT = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] WALK_LAST  = CNT_W'(WALK_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(FLASH_HALF - 1);
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             deb_q, deb_d;
    logic             deb_prev_q, deb_prev_d;
    logic             red_only_q, red_only_d;
    logic             req_q, req_d;
    logic             walk_q, walk_d;
    logic             dont_walk_q, dont_walk_d;
    logic             fault_q, fault_d;

    logic red_only;
    logic red_rise;
    logic illegal;
    logic deb_rise;
    logic start_walk;

    assign red_only = car_red & ~car_yellow & ~car_green;
    assign red_rise = red_only & ~red_only_q;
    assign illegal  = car_red & car_green;
    assign deb_rise = deb_q & ~deb_prev_q;

    // Button synchronizer and debounce: the level flips only after the
    // synchronized input has disagreed with it for DEBOUNCE_CYCLES clocks.
    always_comb begin
        sync1_d    = btn;
        sync2_d    = sync1_q;
        deb_d      = deb_q;
        deb_cnt_d  = '0;
        deb_prev_d = deb_q;
        red_only_d = red_only;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_d     = ~deb_q;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    // Next state, phase timers, request latch and registered lamp outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        half_d      = '0;
        walk_d      = walk_q;
        dont_walk_d = dont_walk_q;
        fault_d     = fault_q;
        req_d       = req_q;
        start_walk  = 1'b0;

        case (state_q)
            ST_STOP: begin
                if (illegal) begin
                    state_d = ST_FAULT;
                end else if (red_rise && req_q) begin
                    state_d    = ST_WALK;
                    start_walk = 1'b1;
                end
            end
            ST_WALK: begin
                if (illegal) begin
                    state_d = ST_FAULT;
                end else if (!red_only) begin
                    state_d = ST_STOP;
                end else if (cnt_q == WALK_LAST) begin
                    state_d = ST_FLASH;
                end
            end
            ST_FLASH: begin
                if (illegal) begin
                    state_d = ST_FAULT;
                end else if (!red_only) begin
                    state_d = ST_STOP;
                end else if (cnt_q == FLASH_LAST) begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase

        // Every state entry restarts the phase counter; idle states hold it at 0.
        if (state_d != state_q || state_d == ST_STOP || state_d == ST_FAULT) begin
            cnt_d = '0;
        end

        case (state_d)
            ST_STOP: begin
                walk_d      = 1'b0;
                dont_walk_d = 1'b1;
            end
            ST_WALK: begin
                walk_d      = 1'b1;
                dont_walk_d = 1'b0;
            end
            ST_FLASH: begin
                walk_d = 1'b0;
                if (state_q != ST_FLASH) begin
                    dont_walk_d = 1'b1;
                    half_d      = '0;
                end else if (half_q == HALF_LAST) begin
                    dont_walk_d = ~dont_walk_q;
                    half_d      = '0;
                end else begin
                    half_d = half_q + 1'b1;
                end
            end
            default: begin
                walk_d      = 1'b0;
                dont_walk_d = 1'b1;
                fault_d     = 1'b1;
            end
        endcase

        // Set on a debounced press in STOP/FLASH; the grant clears it and wins.
        if (deb_rise && (state_q == ST_STOP || state_q == ST_FLASH)) begin
            req_d = 1'b1;
        end
        if (start_walk) begin
            req_d = 1'b0;
        end
    end

    // State register for everything above; reset leaves DON'T-WALK lit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_STOP;
            cnt_q       <= '0;
            half_q      <= '0;
            deb_cnt_q   <= '0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            deb_q       <= 1'b0;
            deb_prev_q  <= 1'b0;
            red_only_q  <= 1'b0;
            req_q       <= 1'b0;
            walk_q      <= 1'b0;
            dont_walk_q <= 1'b1;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            half_q      <= half_d;
            deb_cnt_q   <= deb_cnt_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            deb_q       <= deb_d;
            deb_prev_q  <= deb_prev_d;
            red_only_q  <= red_only_d;
            req_q       <= req_d;
            walk_q      <= walk_d;
            dont_walk_q <= dont_walk_d;
            fault_q     <= fault_d;
        end
    end

    assign walk        = walk_q;
    assign dont_walk   = dont_walk_q;
    assign req_pending = req_q;
    assign phase       = state_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_pedestrian_signal.sv
// Directed bench for pedestrian_signal with short phase parameters.
module tb_pedestrian_signal;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn;
    logic       car_red;
    logic       car_yellow;
    logic       car_green;
    logic       walk;
    logic       dont_walk;
    logic       req_pending;
    logic [1:0] phase;
    logic       fault;

    int n_vec = 0;
    int n_err = 0;

    pedestrian_signal #(
        .WALK_CYCLES    (20),
        .FLASH_CYCLES   (10),
        .FLASH_HALF     (2),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .car_red    (car_red),
        .car_yellow (car_yellow),
        .car_green  (car_green),
        .walk       (walk),
        .dont_walk  (dont_walk),
        .req_pending(req_pending),
        .phase      (phase),
        .fault      (fault)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; btn = 1'b0;
        car_red = 1'b0; car_yellow = 1'b0; car_green = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_vec++; if (phase !== 2'b00) begin n_err++; $display("FAIL rst_phase: got %b want 00", phase); end
        n_vec++; if (walk !== 1'b0) begin n_err++; $display("FAIL rst_walk: got %b want 0", walk); end
        n_vec++; if (dont_walk !== 1'b1) begin n_err++; $display("FAIL rst_dont_walk: got %b want 1", dont_walk); end
        n_vec++; if (req_pending !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", req_pending); end
        n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL rst_fault: got %b want 0", fault); end
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        // Debounced rise lands on edge 6 after the press; request latches on edge 7.
        btn = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            logic exp_req;
            step();
            exp_req = (k == 7);
            n_vec++;
            if (req_pending !== exp_req) begin
                n_err++; $display("FAIL btn_timing edge %0d: req_pending got %b want %b", k, req_pending, exp_req);
            end
        end
        n_vec++; if (phase !== 2'b00) begin n_err++; $display("FAIL btn_phase: got %b want 00", phase); end
        btn = 1'b0;
        repeat (8) step();
    endtask

    task automatic test_normal_walk;
        car_green = 1'b0; car_yellow = 1'b1;
        repeat (3) step();
        n_vec++; if (phase !== 2'b00) begin n_err++; $display("FAIL nw_yellow_phase: got %b want 00", phase); end
        n_vec++; if (req_pending !== 1'b1) begin n_err++; $display("FAIL nw_req_held: got %b want 1", req_pending); end
        car_yellow = 1'b0; car_red = 1'b1;
        step();
        n_vec++; if (req_pending !== 1'b0) begin n_err++; $display("FAIL nw_req_clear: got %b want 0", req_pending); end
        n_vec++; if (phase !== 2'b01 || walk !== 1'b1 || dont_walk !== 1'b0) begin
            n_err++; $display("FAIL nw_walk clk 0: phase=%b walk=%b dw=%b want 01 1 0", phase, walk, dont_walk);
        end
        for (int i = 1; i < 20; i++) begin
            step();
            n_vec++;
            if (phase !== 2'b01 || walk !== 1'b1 || dont_walk !== 1'b0) begin
                n_err++; $display("FAIL nw_walk clk %0d: phase=%b walk=%b dw=%b want 01 1 0", i, phase, walk, dont_walk);
            end
        end
        for (int i = 0; i < 10; i++) begin
            logic exp_dw;
            step();
            exp_dw = (((i / 2) % 2) == 0);
            n_vec++;
            if (phase !== 2'b10 || walk !== 1'b0 || dont_walk !== exp_dw) begin
                n_err++; $display("FAIL nw_flash clk %0d: phase=%b walk=%b dw=%b want 10 0 %b", i, phase, walk, dont_walk, exp_dw);
            end
        end
        step();
        n_vec++; if (phase !== 2'b00 || walk !== 1'b0 || dont_walk !== 1'b1) begin
            n_err++; $display("FAIL nw_end: phase=%b walk=%b dw=%b want 00 0 1", phase, walk, dont_walk);
        end
        repeat (5) step();
        n_vec++; if (phase !== 2'b00) begin n_err++; $display("FAIL nw_no_rewalk: got %b want 00", phase); end
    endtask

    task automatic test_bounce_late;
        // 3-clock glitch never reaches the debounce threshold of 4.
        btn = 1'b1;
        repeat (3) step();
        btn = 1'b0;
        repeat (8) step();
        n_vec++; if (req_pending !== 1'b0) begin n_err++; $display("FAIL glitch_req: got %b want 0", req_pending); end
        car_red = 1'b0; car_green = 1'b1;
        repeat (3) step();
        car_green = 1'b0; car_red = 1'b1;
        step();
        n_vec++; if (phase !== 2'b00) begin n_err++; $display("FAIL late_no_req_rise: got %b want 00", phase); end
        repeat (4) step();
        btn = 1'b1;
        repeat (7) step();
        n_vec++; if (req_pending !== 1'b1) begin n_err++; $display("FAIL late_req: got %b want 1", req_pending); end
        btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_vec++;
            if (phase !== 2'b00) begin n_err++; $display("FAIL late_wait clk %0d: phase got %b want 00", i, phase); end
        end
        car_red = 1'b0; car_green = 1'b1;
        repeat (3) step();
        car_green = 1'b0; car_yellow = 1'b1;
        repeat (2) step();
        n_vec++; if (phase !== 2'b00) begin n_err++; $display("FAIL late_pre_red: got %b want 00", phase); end
        car_yellow = 1'b0; car_red = 1'b1;
        step();
        n_vec++; if (phase !== 2'b01 || walk !== 1'b1 || req_pending !== 1'b0) begin
            n_err++; $display("FAIL late_served: phase=%b walk=%b req=%b want 01 1 0", phase, walk, req_pending);
        end
    endtask

    task automatic test_abort;
        repeat (8) step();
        n_vec++; if (phase !== 2'b01) begin n_err++; $display("FAIL abort_pre: phase got %b want 01", phase); end
        car_yellow = 1'b1;
        step();
        n_vec++; if (phase !== 2'b00 || walk !== 1'b0 || dont_walk !== 1'b1) begin
            n_err++; $display("FAIL abort: phase=%b walk=%b dw=%b want 00 0 1", phase, walk, dont_walk);
        end
        btn = 1'b1;
        repeat (7) step();
        n_vec++; if (req_pending !== 1'b1 || phase !== 2'b00) begin
            n_err++; $display("FAIL abort_press: req=%b phase=%b want 1 00", req_pending, phase);
        end
        btn = 1'b0;
        car_red = 1'b0; car_yellow = 1'b0; car_green = 1'b1;
        repeat (3) step();
        car_green = 1'b0; car_yellow = 1'b1;
        repeat (2) step();
        n_vec++; if (phase !== 2'b00 || req_pending !== 1'b1) begin
            n_err++; $display("FAIL abort_wait: phase=%b req=%b want 00 1", phase, req_pending);
        end
        car_yellow = 1'b0; car_red = 1'b1;
        step();
        n_vec++; if (phase !== 2'b01 || walk !== 1'b1 || req_pending !== 1'b0) begin
            n_err++; $display("FAIL abort_served: phase=%b walk=%b req=%b want 01 1 0", phase, walk, req_pending);
        end
    endtask

    task automatic test_fault;
        repeat (2) step();
        car_green = 1'b1;
        step();
        n_vec++; if (phase !== 2'b11 || fault !== 1'b1 || walk !== 1'b0 || dont_walk !== 1'b1) begin
            n_err++; $display("FAIL fault_enter: phase=%b fault=%b walk=%b dw=%b want 11 1 0 1", phase, fault, walk, dont_walk);
        end
        for (int i = 0; i < 20; i++) begin
            car_red    = ((i % 3) == 2);
            car_yellow = ((i % 3) == 1);
            car_green  = ((i % 3) == 0);
            btn        = (i < 10);
            step();
            n_vec++;
            if (phase !== 2'b11 || fault !== 1'b1 || walk !== 1'b0 || dont_walk !== 1'b1) begin
                n_err++; $display("FAIL fault_hold clk %0d: phase=%b fault=%b walk=%b dw=%b want 11 1 0 1", i, phase, fault, walk, dont_walk);
            end
        end
        #2 rst = 1'b1;
        #1;
        n_vec++; if (phase !== 2'b00 || fault !== 1'b0 || dont_walk !== 1'b1 || walk !== 1'b0) begin
            n_err++; $display("FAIL fault_rst: phase=%b fault=%b dw=%b walk=%b want 00 0 1 0", phase, fault, dont_walk, walk);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        n_vec++; if (phase !== 2'b00 || fault !== 1'b0) begin
            n_err++; $display("FAIL fault_after_rst: phase=%b fault=%b want 00 0", phase, fault);
        end
    endtask

    // Scenario sequence and final report.
    initial begin
        test_reset();
        test_normal_walk();
        test_bounce_late();
        test_abort();
        test_fault();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pedestrian_signal.md
Name: pedestrian_signal

Overview:
- Downstream companion of the vehicle traffic-light controller: consumes its car_red/car_yellow/car_green lamp outputs and drives the pedestrian WALK/DON'T-WALK lamps.
- Latches a debounced push-button request and grants a walk phase only at the start of a pure-red vehicle phase.
- Aborts the walk phase as soon as the vehicle light leaves pure red.
- Detects illegal vehicle lamp combinations and latches a fault.

Parameters:
- WALK_CYCLES, 600000, clocks walk stays lit (≥1).
- FLASH_CYCLES, 300000, clocks of the flashing clearance phase (≥1).
- FLASH_HALF, 50000, clocks per dont_walk on/off half-period in FLASH (≥1).
- DEBOUNCE_CYCLES, 10000, clocks the synchronized button must be stable before the debounced level changes (≥1).
- CNT_W, 32, width of the shared phase counter; must hold max(WALK_CYCLES, FLASH_CYCLES, DEBOUNCE_CYCLES).

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst, input, 1, reset, asynchronous, active-high.
- btn, input, 1, raw asynchronous pedestrian push button, active-high.
- car_red, input, 1, vehicle red lamp.
- car_yellow, input, 1, vehicle yellow lamp.
- car_green, input, 1, vehicle green lamp.
- walk, output, 1, pedestrian WALK lamp (registered).
- dont_walk, output, 1, pedestrian DON'T-WALK lamp (registered).
- req_pending, output, 1, request latched and not yet served (registered).
- phase, output, 2, current state: 00 STOP, 01 WALK, 10 FLASH, 11 FAULT.
- fault, output, 1, sticky illegal-input flag (registered).

Behaviour:
- Reset (rst=1, asynchronous): state STOP, walk=0, dont_walk=1, req_pending=0, fault=0, phase=00. All counters, synchronizer flops, debounced level and the edge-detect register go to 0.
- Button path:
  - 2-flop synchronizer, then debounce counter. The counter counts consecutive cycles the synchronized value differs from the debounced level, and clears when they match.
  - On reaching DEBOUNCE_CYCLES the debounced level flips.
  - A clean btn rise produces a debounced rise exactly DEBOUNCE_CYCLES+2 clocks later; req_pending sets on the following edge.
- Request latch:
  - A debounced rising edge sets req_pending in STOP and FLASH.
  - It is ignored in WALK and FAULT.
  - Cleared on the STOP→WALK transition. If set and clear coincide, clear wins.
- Pure red: red_only = car_red & ~car_yellow & ~car_green. It is registered each cycle to form red_rise = red_only & ~red_only_q.
- Illegal input: car_red & car_green in any cycle, any state. The next edge enters FAULT, sets fault=1, and drives walk=0, dont_walk=1. Only rst exits FAULT.
- STOP → WALK:
  - Taken on the edge where red_rise=1 and req_pending=1 (req_pending already high before that edge).
  - A request arriving mid-red waits for the next red_rise; it never starts late in a red phase.
- WALK: walk=1, dont_walk=0 for exactly WALK_CYCLES clocks, then FLASH.
- FLASH:
  - walk=0 for FLASH_CYCLES clocks.
  - dont_walk=1 for the first FLASH_HALF clocks, then toggles every FLASH_HALF clocks.
  - At expiry: STOP with dont_walk=1.
- Abort: in WALK or FLASH, red_only=0 forces STOP on the next edge (walk=0, dont_walk=1). Any pending request is kept.
- Precedence per edge: rst > illegal input > abort > timer expiry > request start.
- Counter resets to 0 on every state entry. Phase timing is independent of the upstream controller's count.

Test Plan (WALK_CYCLES=20, FLASH_CYCLES=10, FLASH_HALF=2, DEBOUNCE_CYCLES=4):
1. Reset and button timing:
   - Stimulus: rst pulse mid-cycle, then btn held high from cycle 10.
   - Required: walk=0, dont_walk=1, phase=00 asynchronously on reset; debounced rise at cycle 16; req_pending=1 after cycle 17 edge.
2. Normal walk cycle:
   - Stimulus: req_pending=1, car lamps go green→yellow→red.
   - Required: walk=1 one edge after red rise, held 20 clocks; FLASH 10 clocks with dont_walk pattern 1,1,0,0,1,1,0,0,1,1; then STOP, req_pending=0.
3. Bounce and late request:
   - Stimulus: btn glitch high for 3 clocks → no request. Separately, btn pressed 5 clocks after red rise.
   - Required: late request waits; walk starts only at the next red rise.
4. Abort:
   - Stimulus: car_yellow=1 (red+yellow) at WALK clock 8.
   - Required: next edge phase=00, walk=0, dont_walk=1. A press during the following FLASH-free STOP is latched and served at the next red rise.
5. Fault:
   - Stimulus: car_red=car_green=1 for one cycle during WALK.
   - Required: phase=11, fault=1, dont_walk=1, held through later legal inputs and button presses until rst.
